// File: rtl/conv_scheduler.sv
// Sequencing controller for the conv 3x3 MAC datapath: walks one matrix x matrix
// map in raster order, issues window reads and conv_en, and hands results downstream.
module conv_scheduler #(
    parameter  int unsigned SIZE = 23,
    localparam int unsigned DW   = 2 * SIZE - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [4:0]    cfg_matrix_i,
    input  logic          cfg_dense_i,
    output logic          rd_en_o,
    output logic [9:0]    i_o,
    output logic [1:0]    prov_o,
    output logic [4:0]    matrix_o,
    output logic [9:0]    matrix2_o,
    output logic          conv_en_o,
    output logic          dense_en_o,
    input  logic [DW-1:0] y_in_i,
    output logic          res_valid_o,
    input  logic          res_ready_i,
    output logic [DW-1:0] res_data_o,
    output logic [9:0]    res_addr_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          cfg_err_o
);

    localparam int unsigned IW = 10;
    localparam int unsigned MW = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CONV,
        S_WB,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [MW-1:0] col_q, col_d;
    logic [MW-1:0] matrix_q, matrix_d;
    logic [IW-1:0] matrix2_q, matrix2_d;
    logic          dense_q, dense_d;
    logic [1:0]    prov_q, prov_d;
    logic          rd_en_q, rd_en_d;
    logic          conv_en_q, conv_en_d;
    logic          res_valid_q, res_valid_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic [IW-1:0] res_addr_q, res_addr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          cfg_err_q, cfg_err_d;
    logic          last_pos;

    assign last_pos = dense_q || (i_q == (matrix2_q - IW'(1)));

    // State and all output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            col_q       <= '0;
            matrix_q    <= '0;
            matrix2_q   <= '0;
            dense_q     <= 1'b0;
            prov_q      <= 2'b00;
            rd_en_q     <= 1'b0;
            conv_en_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            col_q       <= col_d;
            matrix_q    <= matrix_d;
            matrix2_q   <= matrix2_d;
            dense_q     <= dense_d;
            prov_q      <= prov_d;
            rd_en_q     <= rd_en_d;
            conv_en_q   <= conv_en_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_addr_q  <= res_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Next state; strobes are derived from the next state so they are registered
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        col_d       = col_q;
        matrix_d    = matrix_q;
        dense_d     = dense_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_addr_d  = res_addr_q;
        cfg_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    if ((cfg_matrix_i >= MW'(2)) || cfg_dense_i) begin
                        matrix_d = cfg_matrix_i;
                        dense_d  = cfg_dense_i;
                        i_d      = '0;
                        col_d    = '0;
                        state_d  = S_FETCH;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_FETCH: state_d = S_CONV;
            S_CONV: begin
                // Y1 is valid by the end of CONV, so capture on the WB entry edge
                res_data_d  = y_in_i;
                res_addr_d  = i_q;
                res_valid_d = 1'b1;
                state_d     = S_WB;
            end
            S_WB: begin
                res_valid_d = 1'b1;
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    if (last_pos) begin
                        state_d = S_DONE;
                    end else begin
                        i_d     = i_q + IW'(1);
                        col_d   = (col_q == (matrix_q - MW'(1))) ? '0 : col_q + MW'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort_i && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            res_valid_d = 1'b0;
        end

        rd_en_d   = (state_d == S_FETCH);
        conv_en_d = (state_d == S_CONV);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        matrix2_d = IW'(matrix_d) * IW'(matrix_d);

        if (dense_d) begin
            prov_d = 2'b00;
        end else if (col_d == '0) begin
            prov_d = 2'b11;
        end else if (col_d == (matrix_d - MW'(1))) begin
            prov_d = 2'b10;
        end else begin
            prov_d = 2'b00;
        end
    end

    assign rd_en_o     = rd_en_q;
    assign i_o         = i_q;
    assign prov_o      = prov_q;
    assign matrix_o    = matrix_q;
    assign matrix2_o   = matrix2_q;
    assign conv_en_o   = conv_en_q;
    assign dense_en_o  = dense_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_addr_o  = res_addr_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_conv_scheduler.sv
// Directed self-checking bench for conv_scheduler: full maps, stall, dense,
// config reject, 31x31 map, abort and asynchronous reset.
module tb_conv_scheduler;

    localparam int unsigned SIZE = 23;
    localparam int unsigned DW   = 2 * SIZE - 1;

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic          abort_i;
    logic [4:0]    cfg_matrix_i;
    logic          cfg_dense_i;
    logic          rd_en_o;
    logic [9:0]    i_o;
    logic [1:0]    prov_o;
    logic [4:0]    matrix_o;
    logic [9:0]    matrix2_o;
    logic          conv_en_o;
    logic          dense_en_o;
    logic [DW-1:0] y_in;
    logic          res_valid_o;
    logic          res_ready_i;
    logic [DW-1:0] res_data_o;
    logic [9:0]    res_addr_o;
    logic          busy_o;
    logic          done_o;
    logic          cfg_err_o;

    int n_checks = 0;
    int n_errors = 0;
    bit corrupt  = 1'b0;

    conv_scheduler #(.SIZE(SIZE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .cfg_matrix_i (cfg_matrix_i),
        .cfg_dense_i  (cfg_dense_i),
        .rd_en_o      (rd_en_o),
        .i_o          (i_o),
        .prov_o       (prov_o),
        .matrix_o     (matrix_o),
        .matrix2_o    (matrix2_o),
        .conv_en_o    (conv_en_o),
        .dense_en_o   (dense_en_o),
        .y_in_i       (y_in),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_data_o   (res_data_o),
        .res_addr_o   (res_addr_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .cfg_err_o    (cfg_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] yfun(input logic [9:0] k);
        return DW'(k) * DW'(4099) + DW'(32'h0123_4567);
    endfunction

    // Stand-in for conv.Y1: a known function of the pixel index, or junk while stalled
    always_comb y_in = corrupt ? DW'(64'h0000_1BAD_F00D) : yfun(i_o);

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full map from an idle DUT; start is accepted at cycle 0
    task automatic run_map(input int m, input bit d, input int stall_at, input int stall_len);
        int cyc, nconv, nres, nerr, exp_n, done_cyc, stall_left, col, exp_prov, exp_done;
        exp_n      = d ? 1 : m * m;
        stall_left = (stall_at >= 0 && stall_at < exp_n) ? stall_len : 0;
        exp_done   = 3 * exp_n + 1 + stall_left;
        cfg_matrix_i = 5'(m);
        cfg_dense_i  = d;
        res_ready_i  = 1'b1;
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
        cfg_matrix_i = 5'd1;
        cfg_dense_i  = ~d;
        cyc = 1; nconv = 0; nres = 0; nerr = 0; done_cyc = -1;
        check_val("first_fetch_rd_en", 64'(rd_en_o), 64'd1);
        check_val("matrix", 64'(matrix_o), 64'(m));
        check_val("matrix2", 64'(matrix2_o), 64'(d ? 0 : m * m));
        check_val("dense_en", 64'(dense_en_o), 64'(d));
        while (cyc < 4000) begin
            if (cfg_err_o) nerr++;
            if (conv_en_o) begin
                col      = (m > 0) ? nres % m : 0;
                exp_prov = d ? 0 : (col == 0 ? 3 : (col == m - 1 ? 2 : 0));
                check_val("conv_i", 64'(i_o), 64'(nres));
                check_val("conv_prov", 64'(prov_o), 64'(exp_prov));
                nconv++;
            end
            if (done_o) begin
                done_cyc = cyc;
                break;
            end
            if (res_valid_o && int'(res_addr_o) == stall_at && stall_left > 0) begin
                res_ready_i = 1'b0;
                corrupt     = 1'b1;
                stall_left--;
                check_val("stall_addr", 64'(res_addr_o), 64'(stall_at));
                check_val("stall_data", 64'(res_data_o), 64'(yfun(10'(stall_at))));
            end else begin
                res_ready_i = 1'b1;
                if (res_valid_o) begin
                    check_val("res_addr", 64'(res_addr_o), 64'(nres));
                    check_val("res_data", 64'(res_data_o), 64'(yfun(10'(nres))));
                    nres++;
                end
            end
            tick();
            corrupt = 1'b0;
            cyc++;
        end
        if (done_cyc < 0) check_val("done_timeout", 64'd0, 64'd1);
        check_val("done_cycle", 64'(done_cyc), 64'(exp_done));
        check_val("num_results", 64'(nres), 64'(exp_n));
        check_val("num_conv_en", 64'(nconv), 64'(exp_n));
        check_val("no_cfg_err", 64'(nerr), 64'd0);
        res_ready_i = 1'b1;
        tick();
        check_val("busy_after_done", 64'(busy_o), 64'd0);
        check_val("done_one_cycle", 64'(done_o), 64'd0);
    endtask

    initial begin
        int cyc;
        int ndone;
        rst_n        = 1'b0;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        cfg_matrix_i = 5'd0;
        cfg_dense_i  = 1'b0;
        res_ready_i  = 1'b1;
        tick();
        tick();
        check_val("rst_busy", 64'(busy_o), 64'd0);
        check_val("rst_rd_en", 64'(rd_en_o), 64'd0);
        check_val("rst_res_valid", 64'(res_valid_o), 64'd0);
        check_val("rst_matrix2", 64'(matrix2_o), 64'd0);
        check_val("rst_prov", 64'(prov_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_map(4, 1'b0, -1, 0);
        run_map(3, 1'b0, 4, 5);
        run_map(0, 1'b1, -1, 0);

        // Rejected configuration
        cfg_matrix_i = 5'd1;
        cfg_dense_i  = 1'b0;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        check_val("cfg_err_pulse", 64'(cfg_err_o), 64'd1);
        check_val("cfg_err_busy", 64'(busy_o), 64'd0);
        check_val("cfg_err_rd_en", 64'(rd_en_o), 64'd0);
        tick();
        check_val("cfg_err_single", 64'(cfg_err_o), 64'd0);
        check_val("cfg_err_idle", 64'(busy_o | rd_en_o), 64'd0);

        run_map(31, 1'b0, -1, 0);

        // Abort in WB at i=7, with a simultaneous start that must be ignored
        cfg_matrix_i = 5'd4;
        cfg_dense_i  = 1'b0;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        cyc = 0;
        while (cyc < 200 && !(res_valid_o && res_addr_o == 10'd7)) begin
            tick();
            cyc++;
        end
        check_val("abort_reach_wb", 64'(res_valid_o && res_addr_o == 10'd7), 64'd1);
        abort_i     = 1'b1;
        start_i     = 1'b1;
        res_ready_i = 1'b0;
        tick();
        abort_i     = 1'b0;
        start_i     = 1'b0;
        res_ready_i = 1'b1;
        check_val("abort_busy", 64'(busy_o), 64'd0);
        check_val("abort_res_valid", 64'(res_valid_o), 64'd0);
        ndone = 0;
        for (int k = 0; k < 5; k++) begin
            if (done_o || busy_o) ndone++;
            tick();
        end
        check_val("abort_no_done", 64'(ndone), 64'd0);
        run_map(4, 1'b0, -1, 0);

        // Asynchronous reset during CONV
        cfg_matrix_i = 5'd4;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        check_val("pre_rst_conv_en", 64'(conv_en_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_conv_en", 64'(conv_en_o), 64'd0);
        check_val("arst_busy", 64'(busy_o), 64'd0);
        check_val("arst_matrix", 64'(matrix_o), 64'd0);
        check_val("arst_matrix2", 64'(matrix2_o), 64'd0);
        check_val("arst_prov", 64'(prov_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_val("post_rst_done", 64'(done_o), 64'd0);
        check_val("post_rst_busy", 64'(busy_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
